sc_reply_framer: RTL

Slow-control reply framer sitting directly upstream of the UDP slow-control-to-DCS-FIFO converter. It collects reply payload bytes from the slow-control register engine into a two-slot ping-pong buffer, latches UDP addressing per frame, and drives the converter's `sctx_*` request/ack/start/data/done protocol. Each committed reply becomes one UDP frame in the DCS receive FIFO.

---
 rtl/sc_reply_framer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sc_reply_framer.sv
// rtl/sc_reply_framer.sv - slow-control reply framer: ping-pong reply buffer feeding the sctx_* UDP converter
module sc_reply_framer #(
   parameter int BufAddrW   = 9,
   parameter int DataLead   = 11,
   parameter int AckTimeout = 1024
) (
   input  logic        clk125m,
   input  logic        reset_n,
   input  logic        rply_wr_en,
   input  logic [7:0]  rply_wr_data,
   input  logic        rply_commit,
   input  logic        rply_abort,
   input  logic [31:0] rply_dst_ip,
   input  logic [15:0] rply_dst_port,
   input  logic [15:0] rply_src_port,
   output logic        rply_full,
   output logic        sctx_req,
   input  logic        sctx_ack,
   input  logic        sctx_txdatardy,
   output logic        sctx_start,
   output logic        sctx_stop,
   output logic        sctx_done,
   output logic [7:0]  sctx_data,
   output logic [15:0] sctx_length,
   output logic [15:0] sctx_udptxSrcPort,
   output logic [15:0] sctx_udptxDstPort,
   output logic [31:0] sctx_udptxDstIP,
   output logic        sc_tx_timeout,
   output logic        sc_ovf_err
);

   localparam int LenW = BufAddrW + 1;
   localparam int TmoW = $clog2(AckTimeout + 1);
   localparam int CntW = (TmoW > LenW) ? TmoW : LenW;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT_RDY, S_START, S_LEAD, S_DATA, S_DONE
   } state_t;

   logic [7:0]      mem [0:(2**LenW)-1];
   logic [7:0]      rd_q;
   logic [1:0]      slot_vld;
   logic [LenW-1:0] slot_len   [2];
   logic [31:0]     slot_ip    [2];
   logic [15:0]     slot_dport [2];
   logic [15:0]     slot_sport [2];

   logic            fill_slot;
   logic [LenW-1:0] fill_cnt;
   logic            fill_ovf;
   logic            wr_ok, wr_drop, ovf_now, commit_ok;
   logic [LenW-1:0] commit_len;

   state_t          state, state_nx;
   logic            tx_slot;
   logic [CntW-1:0] cnt;
   logic [LenW-1:0] tx_len;
   logic            tmo_now, slot_free, last_byte;
   logic [BufAddrW-1:0] rd_idx;

   // Fill side: the fill slot is only ever a free slot unless both are taken
   assign rply_full  = &slot_vld;
   assign wr_ok      = rply_wr_en && !rply_full && !fill_cnt[BufAddrW];
   assign wr_drop    = rply_wr_en && !rply_full && fill_cnt[BufAddrW];
   assign ovf_now    = fill_ovf || wr_drop;
   assign commit_len = fill_cnt + LenW'(wr_ok);
   assign commit_ok  = rply_commit && !rply_abort && !ovf_now &&
                       (commit_len != '0) && !slot_vld[fill_slot];

   always_ff @(posedge clk125m) begin
      if (wr_ok)
         mem[{fill_slot, fill_cnt[BufAddrW-1:0]}] <= rply_wr_data;
      rd_q <= mem[{tx_slot, rd_idx}];
   end

   always_ff @(posedge clk125m) begin
      if (commit_ok) begin
         slot_len[fill_slot]   <= commit_len;
         slot_ip[fill_slot]    <= rply_dst_ip;
         slot_dport[fill_slot] <= rply_dst_port;
         slot_sport[fill_slot] <= rply_src_port;
      end
   end

   always_ff @(posedge clk125m or negedge reset_n) begin
      if (!reset_n) begin
         fill_slot  <= 1'b0;
         fill_cnt   <= '0;
         fill_ovf   <= 1'b0;
         slot_vld   <= 2'b00;
         sc_ovf_err <= 1'b0;
      end else begin
         sc_ovf_err <= rply_commit && !rply_abort && ovf_now;
         if (rply_commit || rply_abort) begin
            fill_cnt <= '0;
            fill_ovf <= 1'b0;
         end else begin
            if (wr_ok)   fill_cnt <= fill_cnt + LenW'(1);
            if (wr_drop) fill_ovf <= 1'b1;
         end
         if (slot_free) slot_vld[tx_slot] <= 1'b0;
         if (commit_ok) begin
            slot_vld[fill_slot] <= 1'b1;
            fill_slot           <= ~fill_slot;
         end
      end
   end

   // TX FSM: state register, counters and per-frame latched addressing
   always_ff @(posedge clk125m or negedge reset_n) begin
      if (!reset_n) begin
         state             <= S_IDLE;
         cnt               <= '0;
         tx_slot           <= 1'b0;
         tx_len            <= '0;
         sc_tx_timeout     <= 1'b0;
         sctx_length       <= '0;
         sctx_udptxSrcPort <= '0;
         sctx_udptxDstPort <= '0;
         sctx_udptxDstIP   <= '0;
      end else begin
         state         <= state_nx;
         sc_tx_timeout <= tmo_now;
         // the ack timeout spans REQ and WAIT_RDY, so that hop keeps counting
         if (state == S_IDLE ||
             (state_nx != state && !(state == S_REQ && state_nx == S_WAIT_RDY)))
            cnt <= '0;
         else
            cnt <= cnt + CntW'(1);
         if (slot_free) tx_slot <= ~tx_slot;
         if (state == S_IDLE && state_nx == S_REQ) begin
            if (slot_vld[tx_slot]) begin
               tx_len            <= slot_len[tx_slot];
               sctx_length       <= 16'(slot_len[tx_slot]) + 16'd8;
               sctx_udptxDstIP   <= slot_ip[tx_slot];
               sctx_udptxDstPort <= slot_dport[tx_slot];
               sctx_udptxSrcPort <= slot_sport[tx_slot];
            end else begin
               tx_len            <= commit_len;
               sctx_length       <= 16'(commit_len) + 16'd8;
               sctx_udptxDstIP   <= rply_dst_ip;
               sctx_udptxDstPort <= rply_dst_port;
               sctx_udptxSrcPort <= rply_src_port;
            end
         end
      end
   end

   assign last_byte = (cnt == CntW'(tx_len) - CntW'(1));
   assign slot_free = (state == S_DONE) || tmo_now;

   always_comb begin
      state_nx = state;
      tmo_now  = 1'b0;
      unique case (state)
         S_IDLE:
            if (slot_vld[tx_slot] || (commit_ok && fill_slot == tx_slot))
               state_nx = S_REQ;
         S_REQ:
            if (sctx_ack)
               state_nx = S_WAIT_RDY;
            else if (cnt == CntW'(AckTimeout - 1)) begin
               state_nx = S_IDLE;
               tmo_now  = 1'b1;
            end
         S_WAIT_RDY:
            if (sctx_txdatardy)
               state_nx = S_START;
            else if (cnt == CntW'(AckTimeout - 1)) begin
               state_nx = S_IDLE;
               tmo_now  = 1'b1;
            end
         S_START:  state_nx = S_LEAD;
         S_LEAD:   if (cnt == CntW'(DataLead - 2)) state_nx = S_DATA;
         S_DATA:   if (last_byte) state_nx = S_DONE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // read address runs one byte ahead so the RAM register lines up with DATA
   always_comb begin
      sctx_req   = (state == S_REQ);
      sctx_start = (state == S_START);
      sctx_stop  = (state == S_DATA) && last_byte;
      sctx_done  = (state == S_DONE);
      sctx_data  = (state == S_DATA) ? rd_q : 8'h00;
      rd_idx     = (state == S_DATA) ? BufAddrW'(cnt + CntW'(1)) : '0;
   end

endmodule
